// File: rtl/mini_src_pkg.sv
// Shared constants for the write-back path: ALU opcodes, beat destinations and
// the write-back FSM state type.
package mini_src_pkg;

    localparam logic [4:0] ALU_OP_MUL = 5'b01111;
    localparam logic [4:0] ALU_OP_DIV = 5'b10000;
    localparam logic [4:0] ALU_OP_CLR = 5'b11111;

    localparam logic [1:0] DEST_Z  = 2'b00;
    localparam logic [1:0] DEST_LO = 2'b01;
    localparam logic [1:0] DEST_HI = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SEND_Z  = 2'b01,
        ST_SEND_LO = 2'b10,
        ST_SEND_HI = 2'b11
    } wb_state_t;

    // Wide ops return a double-width result that goes out as an LO/HI pair.
    function automatic logic is_wide(input logic [4:0] op);
        return (op == ALU_OP_MUL) || (op == ALU_OP_DIV);
    endfunction

endpackage

// File: rtl/z_writeback_if.sv
// Result-in / beat-out bundle of the write-back block; slave is the block side,
// master is the surrounding pipeline (ALU upstream, register file downstream).
interface z_writeback_if #(
    parameter int DATA_W = 32
);
    logic [4:0]          control;
    logic [2*DATA_W-1:0] result;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_dest;
    logic                out_valid;
    logic                out_ready;
    logic                busy;
    logic                flag_zero;
    logic                flag_neg;

    modport slave (
        input  control, result, in_valid, out_ready,
        output in_ready, out_data, out_dest, out_valid, busy, flag_zero, flag_neg
    );

    modport master (
        output control, result, in_valid, out_ready,
        input  in_ready, out_data, out_dest, out_valid, busy, flag_zero, flag_neg
    );
endinterface

// File: rtl/z_flags.sv
// Condition flags for a captured ALU result; wide ops are judged over the full
// double-width result, narrow ops over the low beat only.
module z_flags
    import mini_src_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [4:0]          control,
    input  logic [2*DATA_W-1:0] result,
    output logic                zero,
    output logic                neg
);

    always_comb begin
        zero = 1'b0;
        neg  = 1'b0;
        if (control == ALU_OP_CLR) begin
            zero = 1'b1;
            neg  = 1'b0;
        end else if (is_wide(control)) begin
            zero = (result == '0);
            neg  = result[2*DATA_W-1];
        end else begin
            zero = (result[DATA_W-1:0] == '0);
            neg  = result[DATA_W-1];
        end
    end

endmodule

// File: rtl/z_writeback.sv
// ALU write-back sequencer: turns one captured result into Z, or LO then HI, beats.
// Optional condition flags are built when Z_WRITEBACK_FLAGS_EN is defined.
module z_writeback
    import mini_src_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              clear,
    z_writeback_if.slave      bus,
    output wb_state_t         dbg_state,
    output logic [DATA_W-1:0] dbg_zlo,
    output logic [DATA_W-1:0] dbg_zhi
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; a valid side holds its payload unchanged until that edge.
    wb_state_t         state;
    logic [DATA_W-1:0] zlo;
    logic [DATA_W-1:0] zhi;
    logic [DATA_W-1:0] out_data_q;
    logic [1:0]        out_dest_q;
    logic              out_valid_q;
    logic              in_ready_q;
    logic              capture;
    logic [DATA_W-1:0] res_lo;
    logic [DATA_W-1:0] res_hi;

    assign capture = bus.in_valid && in_ready_q;
    assign res_lo  = bus.result[DATA_W-1:0];
    assign res_hi  = bus.result[2*DATA_W-1:DATA_W];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= ST_IDLE;
            zlo         <= '0;
            zhi         <= '0;
            out_data_q  <= '0;
            out_dest_q  <= DEST_Z;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        if (is_wide(bus.control)) begin
                            zlo         <= res_lo;
                            zhi         <= res_hi;
                            out_data_q  <= res_lo;
                            out_dest_q  <= DEST_LO;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state       <= ST_SEND_LO;
                        end else if (bus.control == ALU_OP_CLR) begin
                            zlo <= '0;
                            zhi <= '0;
                        end else begin
                            // Narrow ops leave zhi holding the last wide result.
                            zlo         <= res_lo;
                            out_data_q  <= res_lo;
                            out_dest_q  <= DEST_Z;
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state       <= ST_SEND_Z;
                        end
                    end
                end
                ST_SEND_Z, ST_SEND_HI: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_SEND_LO: begin
                    if (bus.out_ready) begin
                        out_data_q <= zhi;
                        out_dest_q <= DEST_HI;
                        state      <= ST_SEND_HI;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef Z_WRITEBACK_FLAGS_EN
    logic fz_next;
    logic fn_next;
    logic fz_q;
    logic fn_q;

    z_flags #(.DATA_W(DATA_W)) u_flags (
        .control (bus.control),
        .result  (bus.result),
        .zero    (fz_next),
        .neg     (fn_next)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            fz_q <= 1'b0;
            fn_q <= 1'b0;
        end else if (capture) begin
            fz_q <= fz_next;
            fn_q <= fn_next;
        end
    end

    assign bus.flag_zero = fz_q;
    assign bus.flag_neg  = fn_q;
`else
    assign bus.flag_zero = 1'b0;
    assign bus.flag_neg  = 1'b0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_dest  = out_dest_q;
    assign bus.busy      = (state != ST_IDLE);

    assign dbg_state = state;
    assign dbg_zlo   = zlo;
    assign dbg_zhi   = zhi;

endmodule

// File: tb/tb_z_writeback.sv
// Directed plus randomised bench for z_writeback; beats are checked against a
// queue of expected {dest, data} pushed when each result is driven.
module tb_z_writeback;
    import mini_src_pkg::*;

    localparam int DATA_W = 32;
    localparam int BEAT_W = DATA_W + 2;
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
`ifdef Z_WRITEBACK_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic              clock;
    logic              clear;
    wb_state_t         dbg_state;
    logic [DATA_W-1:0] dbg_zlo;
    logic [DATA_W-1:0] dbg_zhi;

    z_writeback_if #(.DATA_W(DATA_W)) bus ();

    z_writeback #(.DATA_W(DATA_W)) dut (
        .clock     (clock),
        .clear     (clear),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_zlo   (dbg_zlo),
        .dbg_zhi   (dbg_zhi)
    );

    int checks = 0;
    int errors = 0;
    int beats = 0;
    int exp_beats = 0;
    logic [BEAT_W-1:0] exp_q[$];
    logic [1:0] exp_flags;

    // Clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_flags(input logic [4:0] op, input logic [63:0] res);
        logic [1:0] f;
        if (op == ALU_OP_CLR)
            f = 2'b10;
        else if (op == ALU_OP_MUL || op == ALU_OP_DIV)
            f = {res == 64'd0, res[63]};
        else
            f = {res[31:0] == 32'd0, res[31]};
        return f & {2{FLAGS_ON}};
    endfunction

    // Scoreboard: a beat transfers on the next rising edge when valid && ready here.
    always @(negedge clock) begin
        if (clear && bus.out_valid && bus.out_ready) begin
            beats++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL beat_unexpected observed=%0h expected=none", {bus.out_dest, bus.out_data});
            end
            if (exp_q.size() != 0)
                check("beat", {30'd0, bus.out_dest, bus.out_data}, {30'd0, exp_q.pop_front()});
        end
    end

    // Driver tasks
    task automatic wait_idle(input bit rand_ready);
        for (int i = 0; i < 64 && !bus.in_ready; i++) begin
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
        end
        check("wait_idle", {63'd0, bus.in_ready}, 64'd1);
    endtask

    task automatic send(input logic [4:0] op, input logic [63:0] res, input bit rand_ready);
        logic [31:0] lo;
        logic [31:0] hi;
        wait_idle(rand_ready);
        lo = res[31:0];
        hi = res[63:32];
        bus.control  = op;
        bus.result   = res;
        bus.in_valid = 1'b1;
        if (op == ALU_OP_MUL || op == ALU_OP_DIV) begin
            exp_q.push_back({DEST_LO, lo});
            exp_q.push_back({DEST_HI, hi});
            exp_beats += 2;
        end else if (op != ALU_OP_CLR) begin
            exp_q.push_back({DEST_Z, lo});
            exp_beats += 1;
        end
        exp_flags = model_flags(op, res);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        check("flag_zero", {63'd0, bus.flag_zero}, {63'd0, exp_flags[1]});
        check("flag_neg", {63'd0, bus.flag_neg}, {63'd0, exp_flags[0]});
    endtask

    task automatic add_five_case(input string pfx);
        bus.out_ready = 1'b1;
        send(OP_ADD, 64'h0000_0000_0000_0005, 1'b0);
        check({pfx, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
        check({pfx, "_data"}, {32'd0, bus.out_data}, 64'd5);
        check({pfx, "_dest"}, {62'd0, bus.out_dest}, {62'd0, DEST_Z});
        check({pfx, "_in_ready_low"}, {63'd0, bus.in_ready}, 64'd0);
        check({pfx, "_busy"}, {63'd0, bus.busy}, 64'd1);
        @(posedge clock);
        #1;
        check({pfx, "_in_ready_back"}, {63'd0, bus.in_ready}, 64'd1);
        check({pfx, "_valid_drop"}, {63'd0, bus.out_valid}, 64'd0);
    endtask

    initial begin
        logic [4:0]  op;
        logic [63:0] res;

        clear        = 1'b0;
        bus.control  = '0;
        bus.result   = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #22;
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_out_data", {32'd0, bus.out_data}, 64'd0);
        check("rst_out_dest", {62'd0, bus.out_dest}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_flag_zero", {63'd0, bus.flag_zero}, 64'd0);
        check("rst_flag_neg", {63'd0, bus.flag_neg}, 64'd0);
        check("rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
        check("rst_zlo", {32'd0, dbg_zlo}, 64'd0);
        check("rst_zhi", {32'd0, dbg_zhi}, 64'd0);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1;

        // Narrow op: single Z beat
        add_five_case("add");

        // Wide op: LO then HI
        send(ALU_OP_MUL, 64'h0000_0001_8000_0000, 1'b0);
        check("mul_lo_data", {32'd0, bus.out_data}, 64'h8000_0000);
        check("mul_lo_dest", {62'd0, bus.out_dest}, {62'd0, DEST_LO});
        @(posedge clock);
        #1;
        check("mul_hi_data", {32'd0, bus.out_data}, 64'h1);
        check("mul_hi_dest", {62'd0, bus.out_dest}, {62'd0, DEST_HI});
        @(posedge clock);
        #1;
        check("mul_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // Stalled wide op with ignored in_valid pulses
        bus.out_ready = 1'b0;
        send(ALU_OP_DIV, 64'hDEAD_BEEF_1234_5678, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.control  = OP_ADD;
            bus.result   = 64'd99;
            check("stall_valid", {63'd0, bus.out_valid}, 64'd1);
            check("stall_data", {32'd0, bus.out_data}, 64'h1234_5678);
            check("stall_dest", {62'd0, bus.out_dest}, {62'd0, DEST_LO});
            check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
            @(posedge clock);
            #1;
        end
        bus.in_valid = 1'b0;
        check("stall_state", {62'd0, dbg_state}, {62'd0, ST_SEND_LO});
        bus.out_ready = 1'b1;
        wait_idle(1'b0);

        // Narrow op keeps zhi; zero flag judged on low beat only
        send(OP_ADD, 64'h0000_0001_0000_0000, 1'b0);
        check("narrow_zhi_kept", {32'd0, dbg_zhi}, 64'hDEAD_BEEF);
        check("narrow_zlo", {32'd0, dbg_zlo}, 64'd0);
        send(OP_SUB, 64'h0000_0000_8000_0001, 1'b0);

        // CLR: no beat, registers zeroed
        send(ALU_OP_CLR, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        check("clr_no_valid", {63'd0, bus.out_valid}, 64'd0);
        check("clr_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("clr_busy", {63'd0, bus.busy}, 64'd0);
        check("clr_zlo", {32'd0, dbg_zlo}, 64'd0);
        check("clr_zhi", {32'd0, dbg_zhi}, 64'd0);

        // Random mix with random backpressure
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0: op = ALU_OP_MUL;
                1: op = ALU_OP_DIV;
                2: op = ALU_OP_CLR;
                default: op = 5'($urandom_range(0, 14));
            endcase
            res = {$urandom, $urandom};
            send(op, res, 1'b1);
        end
        bus.out_ready = 1'b1;
        wait_idle(1'b0);

        // Reset during the HI beat
        send(ALU_OP_MUL, 64'h0000_00AA_0000_00BB, 1'b0);
        @(posedge clock);
        #1;
        check("pre_rst_state", {62'd0, dbg_state}, {62'd0, ST_SEND_HI});
        check("pre_rst_dest", {62'd0, bus.out_dest}, {62'd0, DEST_HI});
        clear = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        check("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
        check("mid_rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
        exp_beats -= exp_q.size();
        exp_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("post_rst_quiet", {63'd0, bus.out_valid}, 64'd0);
        end
        add_five_case("post_rst_add");

        repeat (2) @(posedge clock);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("beat_count", 64'(beats), 64'(exp_beats));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z_writeback.md
Z_WRITEBACK -- requirements
Module: z_writeback

Interface
REQ-001 Parameter DATA_W, default 32: width of one output beat; the ALU result width is 2*DATA_W.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 clear  input  1  asynchronous active-low reset.
REQ-004 control  input  5  ALU opcode accompanying the result (same encoding as the ALU).
REQ-005 result  input  64  ALU result bus.
REQ-006 in_valid  input  1  result/control are valid this cycle.
REQ-007 in_ready  output  1  block can accept a result.
REQ-008 out_data  output  32  write-back beat data.
REQ-009 out_dest  output  2  beat destination: 2'b00 Z, 2'b01 LO, 2'b10 HI; 2'b11 unused.
REQ-010 out_valid  output  1  beat on out_data/out_dest is valid.
REQ-011 out_ready  input  1  consumer accepts the beat.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 flag_zero, flag_neg  output  1 each  condition flags of the last captured result.

Function
REQ-014 FSM states: IDLE, SEND_Z, SEND_LO, SEND_HI.
REQ-015 in_ready is 1 only in IDLE; capture occurs on in_valid && in_ready.
REQ-016 On capture of MUL (5'b01111) or DIV (5'b10000): zlo<=result[31:0], zhi<=result[63:32], next state SEND_LO.
REQ-017 On capture of CLR (5'b11111): zlo/zhi<=0, no beat emitted, state stays IDLE.
REQ-018 On capture of any other opcode: zlo<=result[31:0], zhi unchanged, next state SEND_Z.
REQ-019 out_valid is 1 in SEND_Z/SEND_LO/SEND_HI; out_data/out_dest are registered and held stable until out_valid && out_ready.
REQ-020 SEND_Z: out_data=zlo, out_dest=Z; on handshake go to IDLE.
REQ-021 SEND_LO: out_data=zlo, out_dest=LO; on handshake go to SEND_HI.
REQ-022 SEND_HI: out_data=zhi, out_dest=HI; on handshake go to IDLE.
REQ-023 Latency: first beat valid the cycle after capture; minimum 2 cycles capture-to-capture for narrow ops, 3 for wide ops (one mandatory IDLE bubble).
REQ-024 in_valid while in_ready=0 is ignored; the upstream holds its data.
REQ-025 out_ready held low stalls indefinitely with no data change.

Reset
REQ-026 clear low asynchronously forces state IDLE, zlo=zhi=0, out_valid=0, out_data=0, out_dest=2'b00, busy=0, in_ready=1, flag_zero=0, flag_neg=0.
REQ-027 Reset mid-transfer discards pending beats; no beat is emitted after release until a new capture.

Configuration
REQ-028 Macro Z_WRITEBACK_FLAGS_EN defined: on capture, flag_zero=(result==0) over 64 bits for MUL/DIV and over bits [31:0] otherwise; flag_neg=result[63] for MUL/DIV, result[31] otherwise; CLR sets flag_zero=1, flag_neg=0.
REQ-029 Macro undefined: flag_zero and flag_neg are constant 0 and no flag logic is synthesised.

Structure
REQ-030 Shared package mini_src_pkg holds the opcode constants (ALU_OP_MUL, ALU_OP_DIV, ALU_OP_CLR), the out_dest encoding constants, and the FSM state enum.
REQ-031 The flag computation is a sub-module z_flags, instantiated only under Z_WRITEBACK_FLAGS_EN.

Verification
REQ-032 ADD (5'b00011), result=64'h0000_0000_0000_0005, out_ready=1 -> one beat next cycle: out_data=5, out_dest=Z; in_ready returns 1 one cycle later.
REQ-033 MUL, result=64'h0000_0001_8000_0000, out_ready=1 -> beat LO 32'h8000_0000, then beat HI 32'h0000_0001; flag_neg=0, flag_zero=0 (flags build).
REQ-034 DIV with out_ready held 0 for 5 cycles -> out_valid=1 with out_data=zlo stable throughout; in_valid pulses are ignored; beats complete after out_ready rises.
REQ-035 CLR, result=64'hFFFF_FFFF_FFFF_FFFF -> no out_valid, zlo=zhi=0, flag_zero=1 (flags build).
REQ-036 clear asserted during SEND_HI -> out_valid=0 immediately; no HI beat after release; the next ADD capture behaves as in REQ-032.
